// File: rtl/dncounter_if.sv
// Control and status bundle for the dncounter interval timer.
// The master issues start/tick/abort and the slave returns count and status.
interface dncounter_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             reload;
   logic             en;
   logic             abort;
   logic [WIDTH-1:0] cnt;
   logic             busy;
   logic             tc;
   logic             done;

   modport master (
      output start, load_val, reload, en, abort,
      input  cnt, busy, tc, done
   );

   modport slave (
      input  start, load_val, reload, en, abort,
      output cnt, busy, tc, done
   );
endinterface

// File: rtl/dncounter.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// The decrement is a ripple chain of full adders adding all-ones to the count.
//
// state | meaning
// IDLE  | waiting for start, count held at 0
// RUN   | counting down on en ticks, busy high
// DONE  | terminal count reached (one-shot), count held at 0, done high

module fadder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module dncounter #(
   parameter int WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   dncounter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] reload_val, reload_val_nxt;
   logic             reload_flag, reload_flag_nxt;
   logic             tc, tc_nxt;
   logic [WIDTH-1:0] cnt_dec;
   logic [WIDTH-1:0] carry;
   logic             carry_unused;

   // count + all-ones == count - 1 mod 2^WIDTH; the final carry-out is dropped
   assign carry[0] = 1'b0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_dec
      if (i < WIDTH - 1) begin : g_mid
         fadder u_fa (.a(cnt[i]), .b(1'b1), .cin(carry[i]), .sum(cnt_dec[i]), .cout(carry[i+1]));
      end else begin : g_last
         fadder u_fa (.a(cnt[i]), .b(1'b1), .cin(carry[i]), .sum(cnt_dec[i]), .cout(carry_unused));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         reload_val  <= '0;
         reload_flag <= 1'b0;
         tc          <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         reload_val  <= reload_val_nxt;
         reload_flag <= reload_flag_nxt;
         tc          <= tc_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      reload_val_nxt  = reload_val;
      reload_flag_nxt = reload_flag;
      tc_nxt          = 1'b0;
      if (bus.abort) begin
         state_nxt       = IDLE;
         cnt_nxt         = '0;
         reload_flag_nxt = 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  if (bus.load_val != '0) begin
                     cnt_nxt         = bus.load_val;
                     reload_val_nxt  = bus.load_val;
                     reload_flag_nxt = bus.reload;
                     state_nxt       = RUN;
                  end else begin
                     // a zero period terminates immediately and never reloads
                     cnt_nxt         = '0;
                     tc_nxt          = 1'b1;
                     reload_flag_nxt = 1'b0;
                     state_nxt       = DONE;
                  end
               end
            end
            RUN: begin
               if (bus.en) begin
                  if (cnt == WIDTH'(1)) begin
                     tc_nxt = 1'b1;
                     if (reload_flag) begin
                        cnt_nxt = reload_val;
                     end else begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                     end
                  end else begin
                     cnt_nxt = cnt_dec;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.cnt  = cnt;
      bus.tc   = tc;
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
   end
endmodule

// File: tb/tb_dncounter.sv
// Directed bench for dncounter: stimulus pushes expected outputs into a queue,
// a monitor pops and compares one entry per clock after each active edge.
module tb_dncounter;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [WIDTH+2:0] exp_q[$];
   string            name_q[$];

   dncounter_if #(.WIDTH(WIDTH)) bus ();

   dncounter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic compare(input logic [WIDTH+2:0] got, input logic [WIDTH+2:0] exp, input string nm);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got cnt=%0d busy=%0b tc=%0b done=%0b, expected cnt=%0d busy=%0b tc=%0b done=%0b",
                  nm, got[WIDTH+2:3], got[2], got[1], got[0], exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
      end
   endtask

   // monitor: one expected entry per edge, sampled 2 time units after it
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() != 0) begin
            logic [WIDTH+2:0] e;
            string            nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            compare({bus.cnt, bus.busy, bus.tc, bus.done}, e, nm);
         end
      end
   end

   task automatic step(input logic s, input logic [WIDTH-1:0] lv, input logic r, input logic e,
                       input logic a, input logic [WIDTH-1:0] c, input logic b, input logic t,
                       input logic d, input string nm);
      @(negedge clk);
      bus.start    = s;
      bus.load_val = lv;
      bus.reload   = r;
      bus.en       = e;
      bus.abort    = a;
      exp_q.push_back({c, b, t, d});
      name_q.push_back(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start = 1'b0; bus.load_val = '0; bus.reload = 1'b0; bus.en = 1'b0; bus.abort = 1'b0;
      #12;
      compare({bus.cnt, bus.busy, bus.tc, bus.done}, '0, "reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset");

      // reset mid-count
      step(1, 9, 0, 0, 0, 9, 1, 0, 0, "midrst_load");
      step(0, 0, 0, 1, 0, 8, 1, 0, 0, "midrst_t1");
      step(0, 0, 0, 1, 0, 7, 1, 0, 0, "midrst_t2");
      step(0, 0, 0, 1, 0, 6, 1, 0, 0, "midrst_t3");
      @(negedge clk);
      bus.en = 1'b0;
      #2 rst_n = 1'b0;
      #1 compare({bus.cnt, bus.busy, bus.tc, bus.done}, '0, "midrst_async");
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, "midrst_idle");

      // one-shot
      step(1, 5, 0, 1, 0, 5, 1, 0, 0, "oneshot_load");
      for (int i = 4; i >= 1; i--) step(0, 0, 0, 1, 0, 4'(i), 1, 0, 0, "oneshot_dec");
      step(0, 0, 0, 1, 0, 0, 0, 1, 1, "oneshot_tc");
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 1, "oneshot_hold");

      // gated ticks, started directly from DONE
      step(1, 3, 0, 0, 0, 3, 1, 0, 0, "gated_load");
      step(0, 0, 0, 1, 0, 2, 1, 0, 0, "gated_1");
      step(0, 0, 0, 0, 0, 2, 1, 0, 0, "gated_0a");
      step(0, 0, 0, 0, 0, 2, 1, 0, 0, "gated_0b");
      step(0, 0, 0, 1, 0, 1, 1, 0, 0, "gated_1b");
      step(0, 0, 0, 0, 0, 1, 1, 0, 0, "gated_0c");
      step(0, 0, 0, 1, 0, 0, 0, 1, 1, "gated_tc");

      // auto-reload
      step(1, 2, 1, 0, 0, 2, 1, 0, 0, "reload_load");
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0, 1, 1, 0, 0, "reload_dec");
         step(0, 0, 0, 1, 0, 2, 1, 1, 0, "reload_tc");
      end
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, "reload_abort");

      // load zero
      step(1, 0, 1, 0, 0, 0, 0, 1, 1, "zero_load");
      step(0, 0, 0, 1, 0, 0, 0, 0, 1, "zero_hold");

      // full-scale load
      step(1, 15, 0, 0, 0, 15, 1, 0, 0, "max_load");
      for (int i = 14; i >= 1; i--) step(0, 0, 0, 1, 0, 4'(i), 1, 0, 0, "max_dec");
      step(0, 0, 0, 1, 0, 0, 0, 1, 1, "max_tc");
      step(0, 0, 0, 1, 0, 0, 0, 0, 1, "max_nowrap");

      // abort on the final tick
      step(1, 2, 0, 0, 0, 2, 1, 0, 0, "abtc_load");
      step(0, 0, 0, 1, 0, 1, 1, 0, 0, "abtc_dec");
      step(0, 0, 0, 1, 1, 0, 0, 0, 0, "abtc_abort");

      // start ignored in RUN, then start from DONE
      step(1, 5, 0, 0, 0, 5, 1, 0, 0, "runstart_load");
      step(0, 0, 0, 1, 0, 4, 1, 0, 0, "runstart_dec");
      step(1, 9, 0, 1, 0, 3, 1, 0, 0, "runstart_ignored");
      step(0, 0, 0, 1, 0, 2, 1, 0, 0, "runstart_dec2");
      step(0, 0, 0, 1, 0, 1, 1, 0, 0, "runstart_dec3");
      step(0, 0, 0, 1, 0, 0, 0, 1, 1, "runstart_tc");
      step(1, 6, 0, 0, 0, 6, 1, 0, 0, "donestart_load");
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, "final_abort");

      @(negedge clk);
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
